// File: rtl/ap_ctrl_pkg.sv
// rtl/ap_ctrl_pkg.sv - opcodes, FSM states and pass tables for the AP sequencer
package ap_ctrl_pkg;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_COPY = 2'b01;

    typedef enum logic [2:0] {
        IDLE,
        PASS_CMP,
        PASS_W1,
        PASS_W2,
        FIN
    } state_t;

    // ADD additionally runs one init pass before bit 0
    localparam int ADD_PASSES  = 4;
    localparam int COPY_PASSES = 2;

    localparam logic [1:0] ADD_LAST  = 2'(ADD_PASSES - 1);
    localparam logic [1:0] COPY_LAST = 2'(COPY_PASSES - 1);

    // ADD compare key as {C,B_i,A_i}; order matters so rewritten rows never re-match
    function automatic logic [2:0] add_key(input logic [1:0] p);
        case (p)
            2'd0:    return 3'b011;
            2'd1:    return 3'b001;
            2'd2:    return 3'b100;
            default: return 3'b110;
        endcase
    endfunction

    // ADD write value as {C,B_i}
    function automatic logic [1:0] add_wr(input logic [1:0] p);
        case (p)
            2'd0:    return 2'b10;
            2'd1:    return 2'b01;
            2'd2:    return 2'b01;
            default: return 2'b10;
        endcase
    endfunction

    // COPY compare key as {A_i,B_i}
    function automatic logic [1:0] copy_key(input logic p);
        return p ? 2'b01 : 2'b10;
    endfunction

    function automatic logic copy_wr(input logic p);
        return ~p;
    endfunction

    function automatic int clogb2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/ap_seq_ctrl_if.sv
// rtl/ap_seq_ctrl_if.sv - CAM control bus between the sequencer and the CAM array
interface ap_seq_ctrl_if
    import ap_ctrl_pkg::*;
#(
    parameter int WORD_SIZE  = 8,
    parameter int CELL_QUANT = 512,
    parameter int AW         = clogb2(CELL_QUANT)
);

    logic [CELL_QUANT-1:0] cam_tags;
    logic                  cam_mode;
    logic [AW-1:0]         cam_addr;
    logic                  cam_wea;
    logic [WORD_SIZE-1:0]  cam_key;
    logic [WORD_SIZE-1:0]  cam_mask;
    logic [WORD_SIZE-1:0]  cam_dina;
    logic [CELL_QUANT-1:0] cam_wea_ap;
    logic                  cam_col_in;

    modport master (
        input  cam_tags,
        output cam_mode, cam_addr, cam_wea, cam_key, cam_mask,
               cam_dina, cam_wea_ap, cam_col_in
    );

    modport slave (
        output cam_tags,
        input  cam_mode, cam_addr, cam_wea, cam_key, cam_mask,
               cam_dina, cam_wea_ap, cam_col_in
    );

endinterface

// File: rtl/ap_pass_rom.sv
// rtl/ap_pass_rom.sv - maps (op, pass, bit, init) to compare key/mask and write value/mask
module ap_pass_rom
    import ap_ctrl_pkg::*;
#(
    parameter int WORD_SIZE = 8,
    parameter int OP_W      = 3,
    parameter int BW        = 2
) (
    input  logic [1:0]           op,
    input  logic [1:0]           pass_idx,
    input  logic [BW-1:0]        bit_idx,
    input  logic                 init,
    output logic [WORD_SIZE-1:0] key,
    output logic [WORD_SIZE-1:0] cmp_mask,
    output logic [WORD_SIZE-1:0] wr_val,
    output logic [WORD_SIZE-1:0] wr_mask
);

    localparam logic [WORD_SIZE-1:0] ONE = WORD_SIZE'(1);

    logic [WORD_SIZE-1:0] a_oh;
    logic [WORD_SIZE-1:0] b_oh;
    logic [WORD_SIZE-1:0] c_oh;
    logic [2:0]           ak;
    logic [1:0]           aw;
    logic [1:0]           ck;
    logic                 cw;

    assign a_oh = ONE << bit_idx;
    assign b_oh = ONE << (OP_W + int'(bit_idx));
    assign c_oh = ONE << (2 * OP_W);

    assign ak = add_key(pass_idx);
    assign aw = add_wr(pass_idx);
    assign ck = copy_key(pass_idx[0]);
    assign cw = copy_wr(pass_idx[0]);

    always_comb begin
        key      = '0;
        cmp_mask = '0;
        wr_val   = '0;
        wr_mask  = '0;
        if (init) begin
            // empty compare mask matches every row; clears the carry
            wr_mask = c_oh;
        end else if (op == OP_ADD) begin
            key      = (ak[2] ? c_oh : '0) | (ak[1] ? b_oh : '0) | (ak[0] ? a_oh : '0);
            cmp_mask = a_oh | b_oh | c_oh;
            wr_val   = (aw[1] ? c_oh : '0) | (aw[0] ? b_oh : '0);
            wr_mask  = b_oh | c_oh;
        end else if (op == OP_COPY) begin
            key      = (ck[1] ? a_oh : '0) | (ck[0] ? b_oh : '0);
            cmp_mask = a_oh | b_oh;
            wr_val   = cw ? b_oh : '0;
            wr_mask  = b_oh;
        end
    end

endmodule

// File: rtl/ap_seq_ctrl.sv
// rtl/ap_seq_ctrl.sv - bit-serial ADD/COPY sequencer for the AP CAM with idle host access
module ap_seq_ctrl
    import ap_ctrl_pkg::*;
#(
    parameter int WORD_SIZE  = 8,
    parameter int CELL_QUANT = 512,
    parameter int OP_W       = 3,
    parameter int AW         = clogb2(CELL_QUANT)
) (
    input  logic                 CLK100MHZ,
    input  logic                 rst,
    input  logic                 start,
    input  logic [1:0]           op,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    input  logic                 h_we,
    input  logic [AW-1:0]        h_addr,
    input  logic [WORD_SIZE-1:0] h_din,
    output logic                 h_ready,
    ap_seq_ctrl_if.master        cam
);

    localparam int BW = (OP_W > 1) ? $clog2(OP_W) : 1;

    state_t                state_q, state_d;
    logic [1:0]            op_q, op_d;
    logic [1:0]            pass_q, pass_d;
    logic [BW-1:0]         bit_q, bit_d;
    logic                  init_q, init_d;
    logic [CELL_QUANT-1:0] tag_q;
    logic [AW-1:0]         addr_q;

    logic [WORD_SIZE-1:0]  rom_key;
    logic [WORD_SIZE-1:0]  rom_cmp_mask;
    logic [WORD_SIZE-1:0]  rom_wr_val;
    logic [WORD_SIZE-1:0]  rom_wr_mask;
    logic                  last_pass;
    logic                  last_bit;

    ap_pass_rom #(
        .WORD_SIZE (WORD_SIZE),
        .OP_W      (OP_W),
        .BW        (BW)
    ) u_rom (
        .op       (op_q),
        .pass_idx (pass_q),
        .bit_idx  (bit_q),
        .init     (init_q),
        .key      (rom_key),
        .cmp_mask (rom_cmp_mask),
        .wr_val   (rom_wr_val),
        .wr_mask  (rom_wr_mask)
    );

    assign last_pass = (op_q == OP_ADD) ? (pass_q == ADD_LAST) : (pass_q == COPY_LAST);
    assign last_bit  = (bit_q == BW'(OP_W - 1));

    assign busy           = (state_q != IDLE);
    assign h_ready        = ~busy;
    assign cam.cam_col_in = 1'b0;

    always_ff @(posedge CLK100MHZ or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            op_q    <= '0;
            pass_q  <= '0;
            bit_q   <= '0;
            init_q  <= 1'b0;
            tag_q   <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            pass_q  <= pass_d;
            bit_q   <= bit_d;
            init_q  <= init_d;
            if (state_q == PASS_CMP) tag_q <= cam.cam_tags;
            if (state_q == IDLE) addr_q <= h_addr;
        end
    end

    always_comb begin
        state_d        = state_q;
        op_d           = op_q;
        pass_d         = pass_q;
        bit_d          = bit_q;
        init_d         = init_q;
        done           = 1'b0;
        err            = 1'b0;
        cam.cam_mode   = 1'b0;
        cam.cam_addr   = addr_q;
        cam.cam_wea    = 1'b0;
        cam.cam_key    = '0;
        cam.cam_mask   = '0;
        cam.cam_dina   = '0;
        cam.cam_wea_ap = '0;

        case (state_q)
            IDLE: begin
                cam.cam_addr = h_addr;
                cam.cam_dina = h_din;
                cam.cam_wea  = h_we & ~start;
                cam.cam_mask = '1;
                if (start) begin
                    op_d    = op;
                    pass_d  = '0;
                    bit_d   = '0;
                    init_d  = (op == OP_ADD);
                    state_d = op[1] ? FIN : PASS_CMP;
                end
            end
            PASS_CMP: begin
                cam.cam_key  = rom_key;
                cam.cam_mask = rom_cmp_mask;
                state_d      = PASS_W1;
            end
            PASS_W1: begin
                cam.cam_mode   = 1'b1;
                cam.cam_wea_ap = tag_q;
                cam.cam_dina   = rom_wr_val;
                cam.cam_mask   = rom_wr_mask;
                state_d        = PASS_W2;
            end
            PASS_W2: begin
                cam.cam_mode = 1'b1;
                cam.cam_dina = rom_wr_val;
                cam.cam_mask = rom_wr_mask;
                state_d      = PASS_CMP;
                if (init_q) begin
                    init_d = 1'b0;
                end else if (!last_pass) begin
                    pass_d = pass_q + 2'd1;
                end else begin
                    pass_d = '0;
                    if (last_bit) state_d = FIN;
                    else          bit_d   = bit_q + BW'(1);
                end
            end
            FIN: begin
                done    = 1'b1;
                err     = op_q[1];
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // while reset is held the CAM bus reads as zero even though IDLE forwards the host port
        if (rst) begin
            done           = 1'b0;
            err            = 1'b0;
            cam.cam_mode   = 1'b0;
            cam.cam_addr   = '0;
            cam.cam_wea    = 1'b0;
            cam.cam_key    = '0;
            cam.cam_mask   = '0;
            cam.cam_dina   = '0;
            cam.cam_wea_ap = '0;
        end
    end

endmodule
